gray_to_bin_seq: RTL
====================

Name: gray_to_bin_seq

Overview:
Sequential Gray-to-binary decoder. It is the receive-side counterpart to the team's combinational binary-to-Gray encoder. The block accepts one N-bit Gray word through a valid/ready handshake and resolves binary bits MSB-first, STEP bits per clock, using an internal FSM. It then presents the binary word with a valid/ready output handshake. It is used where Gray-coded values (e.g. CDC FIFO pointers, encoder positions) are decoded off the critical path.

Parameters:
N, 16, data width in bits; legal range 1 and above.
STEP, 1, binary bits resolved per CONV cycle; legal range 1 to N.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset; asynchronous, active-low
in_valid  input  1  gray holds a word to be decoded
in_ready  output  1  block can accept a word (high only in IDLE)
gray  input  N  Gray-coded input word
out_valid  output  1  binary holds the decoded result (high only in DONE)
out_ready  input  1  downstream consumes the result
binary  output  N  decoded binary word; registered
busy  output  1  high in CONV or DONE

Behaviour:
- Reset: while rst_n=0, all state is cleared immediately, independent of clk.
  - state=IDLE, in_ready=1, out_valid=0, busy=0, binary=0, internal Gray register=0, bit index=0.
  - Reset asserted mid-operation aborts the conversion. No result is emitted.
  - First accept is possible on the first rising edge after rst_n deasserts.
- Define C = ceil((N-1)/STEP). For N=16: STEP=1 gives C=15; STEP=4 gives C=4. For N=1, C=0.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1:
    - gray is captured into g_reg.
    - binary is loaded with MSB = gray[N-1]; all other bits cleared.
    - index = N-2.
    - Next state is CONV, or DONE if C=0.
  - in_valid=0: stay in IDLE, no change.
- CONV:
  - in_ready=0; the input is ignored.
  - Each edge resolves bits i = index down to max(index-STEP+1, 0), in descending order, with binary[i] = binary[i+1] ^ g_reg[i]. The chain is combinational within the cycle.
  - index decrements by STEP.
  - The final CONV cycle may resolve fewer than STEP bits. Bits below 0 are never touched.
  - After the edge that resolves bit 0, next state is DONE.
- DONE:
  - out_valid=1; binary is held stable.
  - On an edge with out_ready=1: next state is IDLE, out_valid drops.
  - out_ready=0: hold indefinitely; binary and out_valid do not change.
- Latency: out_valid is first high in the cycle following the C-th edge after the accepting edge. For N=1 it is the cycle right after the accept edge.
- Throughput: one word per C+2 cycles minimum (accept, C conversion, handoff). There is no overlap: in_ready is low in DONE even when out_ready=1.
- Result invariants:
  - binary[N-1] = gray[N-1].
  - For i < N-1, binary[i] = XOR of gray[N-1:i].
  - Round trip through the team's encoder is the identity.
- binary between accept and DONE holds partial results and is not meaningful. It is deterministic: unresolved bits are 0.
- in_valid held high across a whole transaction starts a new accept only on return to IDLE. The gray value is sampled only at the accept edge; later changes to gray have no effect.
- No combinational path from any input to any output; all outputs are registered or decoded from state.

Test Plan:
- Reset then idle (N=16, STEP=1) -> in_ready=1, out_valid=0, busy=0, binary=0x0000 during and after reset.
- Basic decode vectors, each accepted with out_ready=1:
  - gray 0x0000 -> binary 0x0000.
  - gray 0x0001 -> binary 0x0001.
  - gray 0x0002 -> binary 0x0003.
  - gray 0x8000 -> binary 0xFFFF.
  - gray 0xC000 -> binary 0x8000.
  - For each, out_valid rises exactly 15 edges after the accept edge.
- Exhaustive round trip (N=16, STEP=1): feed all 65536 values through the binary-to-Gray encoder into this block -> every binary output equals the original value. No accept occurs while busy=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with gray 0x8000 -> out_valid stays 1, binary stays 0xFFFF, in_ready stays 0. Then out_ready=1 -> IDLE on the next edge, in_ready=1.
- Reset mid-CONV: accept gray 0x1234, then pull rst_n low after 7 edges -> all outputs return to reset values immediately with no clk edge needed. No out_valid pulse follows. The next accept of 0x0003 yields 0x0002.
- Parameter variants:
  - N=16, STEP=4, gray 0x8000 -> binary 0xFFFF, out_valid after exactly 4 edges (final step resolves 3 bits).
  - N=1, gray 1 -> binary 1, out_valid in the cycle after the accept edge.

Source files
------------

// File: rtl/gray_to_bin_seq_if.sv
// Handshake bundle for the sequential Gray-to-binary decoder.
// The master side supplies Gray words and consumes results; the slave side is the decoder.
interface gray_to_bin_seq_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] gray;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] binary;
  logic         busy;

  modport master (
    output in_valid,
    output gray,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  binary,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  gray,
    input  out_ready,
    output in_ready,
    output out_valid,
    output binary,
    output busy
  );
endinterface

// File: rtl/gray_to_bin_seq.sv
// Sequential Gray-to-binary decoder.
// Accepts one Gray word, resolves binary bits MSB-first STEP bits per clock,
// then offers the binary word until the consumer takes it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a Gray word; in_ready high
// CONV  | resolving bits idx down to idx-STEP+1 (clipped at 0) each edge
// DONE  | result stable on binary; out_valid high until out_ready
module gray_to_bin_seq #(
  parameter int N    = 16,
  parameter int STEP = 1
) (
  input logic              clk,
  input logic              rst_n,
  gray_to_bin_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CONV cycles; zero for a 1-bit word, which needs no chaining.
  localparam int C  = (N - 1 + STEP - 1) / STEP;
  // Signed index width: holds N-2 down to -STEP without wrapping.
  localparam int IW = $clog2(N + 1) + 1;

  localparam logic signed [IW-1:0] TOP    = IW'(N - 2);
  localparam logic signed [IW-1:0] STEP_S = IW'(STEP);
  localparam logic signed [IW-1:0] ONE    = IW'(1);
  localparam logic signed [IW-1:0] ZERO   = IW'(0);

  state_t                state, state_nxt;
  logic [N-1:0]          g_reg, g_nxt;
  logic [N-1:0]          bin_reg, bin_nxt;
  logic signed [IW-1:0]  idx, idx_nxt;
  logic signed [IW-1:0]  lo;
  logic signed [IW-1:0]  j_s;

  // State, captured word, partial result and bit index; reset aborts any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      g_reg   <= '0;
      bin_reg <= '0;
      idx     <= ZERO;
    end else begin
      state   <= state_nxt;
      g_reg   <= g_nxt;
      bin_reg <= bin_nxt;
      idx     <= idx_nxt;
    end
  end

  // Next-state and datapath: the XOR chain over the current slice settles within one cycle.
  always_comb begin
    state_nxt = state;
    g_nxt     = g_reg;
    bin_nxt   = bin_reg;
    idx_nxt   = idx;
    j_s       = ZERO;
    lo        = idx - STEP_S + ONE;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          g_nxt          = bus.gray;
          bin_nxt        = '0;
          bin_nxt[N-1]   = bus.gray[N-1];
          idx_nxt        = TOP;
          state_nxt      = (C == 0) ? DONE : CONV;
        end
      end
      CONV: begin
        // MSB already equals g_reg[N-1]; re-asserting it keeps the chain seed explicit.
        bin_nxt[N-1] = g_reg[N-1];
        for (int j = N - 2; j >= 0; j--) begin
          j_s = IW'(j);
          if ((j_s <= idx) && (j_s >= lo)) begin
            bin_nxt[j] = bin_nxt[j+1] ^ g_reg[j];
          end
        end
        idx_nxt = idx - STEP_S;
        if (lo <= ZERO) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Handshake outputs are pure state decodes; binary comes straight from its register.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == CONV) || (state == DONE);
  assign bus.binary    = bin_reg;

endmodule
